// File: rtl/approx_eval_pkg.sv
// Shared types and helpers for the approximate-adder error evaluator.
//   state_e      : evaluator FSM states
//   sum_acc_w    : width of the absolute-error sum accumulator
//   cnt_acc_w    : width of the violation counter
//   exact_sum    : reference A+B of a stimulus word, truncated to out_w bits
package approx_eval_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned DEF_IN_W  = 4;
  localparam int unsigned DEF_OUT_W = 3;
  localparam int unsigned DEF_ET    = 2;

  // 2^in_w vectors of at most 2^out_w-1 error each fit in in_w+out_w bits.
  function automatic int unsigned sum_acc_w(input int unsigned in_w, input int unsigned out_w);
    return in_w + out_w;
  endfunction

  // Up to 2^in_w violations need in_w+1 bits.
  function automatic int unsigned cnt_acc_w(input int unsigned in_w);
    return in_w + 1;
  endfunction

  // Operand A is the low half of stim, operand B the high half.
  function automatic logic [31:0] exact_sum(input logic [31:0] stim,
                                            input int unsigned in_w,
                                            input int unsigned out_w);
    logic [31:0] half_mask;
    logic [31:0] out_mask;
    logic [31:0] op_a;
    logic [31:0] op_b;
    half_mask = (32'd1 << (in_w / 2)) - 32'd1;
    op_a      = stim & half_mask;
    op_b      = (stim >> (in_w / 2)) & half_mask;
    out_mask  = (out_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << out_w) - 32'd1);
    return (op_a + op_b) & out_mask;
  endfunction

endpackage

// File: rtl/approx_err_stage.sv
// Error stage: absolute difference between the DUT word and the exact sum,
// threshold compare, and a single pipeline register with a valid flag.
//   clk, rst   : clock, synchronous active-high reset
//   clr        : drop the valid flag (new sweep accepted)
//   en         : capture this cycle's error (sweep cycle)
//   exact      : exact sum for the current stimulus
//   approx     : DUT output word for the current stimulus
//   err_q      : registered absolute error
//   viol_q     : registered (err > ET)
//   valid_q    : stage holds a vector still to be retired
module approx_err_stage
  import approx_eval_pkg::*;
#(
  parameter int unsigned OUT_W = DEF_OUT_W,
  parameter int unsigned ET    = DEF_ET
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [OUT_W-1:0] exact,
  input  logic [OUT_W-1:0] approx,
  output logic [OUT_W-1:0] err_q,
  output logic             viol_q,
  output logic             valid_q
);

  logic [OUT_W-1:0] err_c;
  logic             viol_c;

  // Unsigned |approx - exact|; both operands are OUT_W wide so no overflow.
  always_comb begin
    err_c  = (approx >= exact) ? (approx - exact) : (exact - approx);
    viol_c = (err_c > OUT_W'(ET));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q   <= '0;
      viol_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (clr) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= en;
      if (en) begin
        err_q  <= err_c;
        viol_q <= viol_c;
      end
    end
  end

endmodule

// File: rtl/approx_error_monitor.sv
// Exhaustive error evaluator for a combinational approximate adder.
// Sweeps every input vector, compares the DUT word against A+B and
// accumulates max error, error sum and threshold violations.
//   clk, rst   : clock, synchronous active-high reset
//   start      : begin a sweep (accepted in IDLE or DONE)
//   stim_out   : vector driven to the DUT inputs
//   approx_in  : DUT output word for stim_out
//   busy       : sweep in progress (SWEEP, DRAIN)
//   done       : results valid, held until next start or rst
//   max_err    : largest absolute error
//   err_sum    : sum of absolute errors
//   viol_cnt   : vectors with error > ET
//   pass       : valid with done; 1 iff no violations
module approx_error_monitor
  import approx_eval_pkg::*;
#(
  parameter int unsigned IN_W  = DEF_IN_W,
  parameter int unsigned OUT_W = DEF_OUT_W,
  parameter int unsigned ET    = DEF_ET
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic [IN_W-1:0]         stim_out,
  input  logic [OUT_W-1:0]        approx_in,
  output logic                    busy,
  output logic                    done,
  output logic [OUT_W-1:0]        max_err,
  output logic [IN_W+OUT_W-1:0]   err_sum,
  output logic [IN_W:0]           viol_cnt,
  output logic                    pass
);

  localparam int unsigned SUM_W = sum_acc_w(IN_W, OUT_W);
  localparam int unsigned CNT_W = cnt_acc_w(IN_W);

  state_e           state;
  logic             start_ok_c;
  logic [OUT_W-1:0] exact_c;
  logic [OUT_W-1:0] stg_err;
  logic             stg_viol;
  logic             stg_valid;

  assign start_ok_c = start && ((state == IDLE) || (state == DONE));
  assign exact_c    = OUT_W'(exact_sum(32'(stim_out), IN_W, OUT_W));

  approx_err_stage #(
    .OUT_W (OUT_W),
    .ET    (ET)
  ) u_stage (
    .clk     (clk),
    .rst     (rst),
    .clr     (start_ok_c),
    .en      (state == SWEEP),
    .exact   (exact_c),
    .approx  (approx_in),
    .err_q   (stg_err),
    .viol_q  (stg_viol),
    .valid_q (stg_valid)
  );

  // FSM, stimulus counter and accumulators.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      stim_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      max_err  <= '0;
      err_sum  <= '0;
      viol_cnt <= '0;
    end else begin
      // Retire the staged vector; a start below overrides with a clear.
      if (stg_valid) begin
        if (stg_err > max_err) max_err <= stg_err;
        err_sum  <= err_sum + SUM_W'(stg_err);
        viol_cnt <= viol_cnt + CNT_W'(stg_viol);
      end

      case (state)
        IDLE, DONE: begin
          if (start_ok_c) begin
            state    <= SWEEP;
            stim_out <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            pass     <= 1'b0;
            max_err  <= '0;
            err_sum  <= '0;
            viol_cnt <= '0;
          end else if (state == DONE) begin
            // Counters are final once in DONE; publish the verdict.
            done <= 1'b1;
            pass <= (viol_cnt == '0);
          end
        end
        SWEEP: begin
          if (&stim_out) begin
            state <= DRAIN;
          end else begin
            stim_out <= stim_out + IN_W'(1);
          end
        end
        DRAIN: begin
          state <= DONE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_approx_error_monitor.sv
module tb_approx_error_monitor;

  localparam int unsigned IN_W  = 4;
  localparam int unsigned OUT_W = 3;
  localparam int unsigned ET    = 2;
  localparam int          NV    = 1 << IN_W;
  localparam int          HALF  = 1 << (IN_W / 2);

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [IN_W-1:0]       stim_out;
  logic [OUT_W-1:0]      approx_in;
  logic                  busy;
  logic                  done;
  logic [OUT_W-1:0]      max_err;
  logic [IN_W+OUT_W-1:0] err_sum;
  logic [IN_W:0]         viol_cnt;
  logic                  pass;

  logic [OUT_W-1:0] lut [0:NV-1];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Candidate approximate adder: a lookup table indexed by the stimulus.
  assign approx_in = lut[stim_out];

  approx_error_monitor #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .ET    (ET)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stim_out  (stim_out),
    .approx_in (approx_in),
    .busy      (busy),
    .done      (done),
    .max_err   (max_err),
    .err_sum   (err_sum),
    .viol_cnt  (viol_cnt),
    .pass      (pass)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Table fillers: 0 exact adder, 1 tied to 0, 2 tied to all-ones, 3 random.
  task automatic set_lut(input int kind);
    for (int v = 0; v < NV; v++) begin
      case (kind)
        0:       lut[v] = OUT_W'((v % HALF) + (v / HALF));
        1:       lut[v] = '0;
        2:       lut[v] = '1;
        default: lut[v] = OUT_W'($urandom_range(0, (1 << OUT_W) - 1));
      endcase
    end
  endtask

  // Reference statistics over every vector of the current table.
  task automatic model(output int mx, output int sm, output int vc);
    int e;
    mx = 0; sm = 0; vc = 0;
    for (int v = 0; v < NV; v++) begin
      e = int'(lut[v]) - ((v % HALF) + (v / HALF));
      if (e < 0) e = -e;
      if (e > mx) mx = e;
      sm += e;
      if (e > int'(ET)) vc++;
    end
  endtask

  // Full sweep from the start pulse; optional extra start at cycle restart_at.
  task automatic run_sweep(input string tag, input int restart_at);
    int mx, sm, vc;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, ".busy0"}, int'(busy), 1);
    check({tag, ".done0"}, int'(done), 0);
    check({tag, ".stim0"}, int'(stim_out), 0);
    check({tag, ".clr"}, int'(err_sum), 0);
    for (int k = 1; k <= NV; k++) begin
      tick();
      start = 1'b0;
      check({tag, ".stim"}, int'(stim_out), (k < NV) ? k : NV - 1);
      check({tag, ".busy"}, int'(busy), 1);
      if (k == restart_at) start = 1'b1;
    end
    tick();
    check({tag, ".busy_drain"}, int'(busy), 0);
    check({tag, ".done_early"}, int'(done), 0);
    tick();
    check({tag, ".done18"}, int'(done), 1);
    model(mx, sm, vc);
    check({tag, ".max_err"}, int'(max_err), mx);
    check({tag, ".err_sum"}, int'(err_sum), sm);
    check({tag, ".viol_cnt"}, int'(viol_cnt), vc);
    check({tag, ".pass"}, int'(pass), (vc == 0) ? 1 : 0);
    tick();
    check({tag, ".done_hold"}, int'(done), 1);
    check({tag, ".stim_hold"}, int'(stim_out), NV - 1);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    set_lut(0);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rst.stim", int'(stim_out), 0);
    check("rst.busy", int'(busy), 0);
    check("rst.done", int'(done), 0);
    check("rst.pass", int'(pass), 0);
    check("rst.max", int'(max_err), 0);
    check("rst.sum", int'(err_sum), 0);
    check("rst.viol", int'(viol_cnt), 0);
    rst = 1'b0;
    tick();
    check("idle.busy", int'(busy), 0);

    set_lut(0);
    run_sweep("exact", -1);
    check("exact.max_const", int'(max_err), 0);
    check("exact.pass_const", int'(pass), 1);

    set_lut(1);
    run_sweep("zero", -1);
    check("zero.sum_const", int'(err_sum), 48);
    check("zero.viol_const", int'(viol_cnt), 10);
    check("zero.max_const", int'(max_err), 6);

    set_lut(2);
    run_sweep("seven", -1);
    check("seven.sum_const", int'(err_sum), 64);
    check("seven.viol_const", int'(viol_cnt), 13);
    check("seven.max_const", int'(max_err), 7);

    set_lut(1);
    run_sweep("restart", 5);
    check("restart.sum_const", int'(err_sum), 48);

    // Reset in the middle of a sweep.
    set_lut(3);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 9; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst.stim", int'(stim_out), 0);
    check("midrst.busy", int'(busy), 0);
    check("midrst.done", int'(done), 0);
    check("midrst.max", int'(max_err), 0);
    check("midrst.sum", int'(err_sum), 0);
    check("midrst.viol", int'(viol_cnt), 0);
    tick();
    check("midrst.idle", int'(stim_out), 0);
    run_sweep("after_rst", -1);

    // Back-to-back: start taken directly from DONE.
    set_lut(1);
    run_sweep("b2b_zero", -1);
    set_lut(0);
    run_sweep("b2b_exact", -1);
    check("b2b.pass_const", int'(pass), 1);
    check("b2b.sum_const", int'(err_sum), 0);

    for (int r = 0; r < 6; r++) begin
      set_lut(3);
      run_sweep("rand", (r % 2 == 0) ? 3 + r : -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
